tt_health_packer: RTL

Downstream stage of the TRNG bitstream: consumes the post-processed random bit (`ranbitstring`) one bit per accepted cycle. Runs continuous health tests on it: a repetition-count test (RCT) and an adaptive-proportion test (APT). Packs bits that pass into bytes, MSB first, and delivers them through a small FIFO with a valid/ready handshake. It replaces ad-hoc sampling of the bitstream with a qualified, flow-controlled byte source.

---
 rtl/tt_health_pkg.sv | 17 +
 rtl/tt_bytefifo.sv | 69 ++++++
 rtl/tt_health_packer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tt_health_pkg.sv
// Shared types and default parameters for the TRNG health-test byte packer.
package tt_health_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STARTUP = 2'd1,
        RUN     = 2'd2,
        FAIL    = 2'd3
    } state_t;

    localparam int DEF_RCT_CUTOFF   = 32;
    localparam int DEF_APT_WINDOW   = 512;
    localparam int DEF_APT_CUTOFF   = 410;
    localparam int DEF_STARTUP_BITS = 1024;
    localparam int DEF_FIFO_DEPTH   = 4;

endpackage

// File: rtl/tt_bytefifo.sv
// Byte FIFO with a registered head output; DEPTH must be a power of 2, at least 2.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module tt_bytefifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_next;
    logic          do_pop;
    logic          do_push;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_next = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_next;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // Head register tracks whatever entry will sit at rd_ptr after this edge.
            if (do_pop) begin
                if (level > LW'(1))  dout <= mem[rd_next];
                else if (do_push)    dout <= din;
            end else if (empty && do_push) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/tt_health_packer.sv
// Health-tests (RCT/APT) the conditioned TRNG bitstream and packs passing bits MSB-first into a byte FIFO.
// state   | meaning
// IDLE    | disabled, counters cleared, FIFO may still drain
// STARTUP | STARTUP_BITS bits tested and discarded
// RUN     | bits tested and packed into bytes
// FAIL    | health failure latched, waits for clear_fail
module tt_health_packer
    import tt_health_pkg::*;
#(
    parameter int RCT_CUTOFF   = DEF_RCT_CUTOFF,
    parameter int APT_WINDOW   = DEF_APT_WINDOW,
    parameter int APT_CUTOFF   = DEF_APT_CUTOFF,
    parameter int STARTUP_BITS = DEF_STARTUP_BITS,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          clear_fail,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          rct_fail,
    output logic                          apt_fail,
    output logic [7:0]                    drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int RW = $clog2(RCT_CUTOFF) + 1;
    localparam int WW = $clog2(APT_WINDOW);
    localparam int CW = $clog2(APT_WINDOW) + 1;
    localparam int SW = $clog2(STARTUP_BITS) + 1;

    state_t        state;
    logic          last_bit;
    logic [RW-1:0] run_len;
    logic          apt_ref;
    logic [WW-1:0] apt_pos;
    logic [CW-1:0] apt_cnt;
    logic [SW-1:0] su_cnt;
    logic [6:0]    sh;
    logic [2:0]    bit_idx;

    logic          accept;
    logic          testing;
    logic          clr_tests;
    logic [RW-1:0] run_nxt;
    logic          apt_first;
    logic          apt_match;
    logic [CW-1:0] apt_cnt_nxt;
    logic          rct_hit;
    logic          apt_hit;
    logic          fail_now;
    logic [SW-1:0] su_nxt;
    logic          pack;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    byte_nxt;

    assign accept      = bit_valid & enable;
    assign testing     = accept & ((state == STARTUP) | (state == RUN));
    assign clr_tests   = ((state == STARTUP) | (state == RUN)) & (~enable | fail_now);

    assign run_nxt     = (bit_in == last_bit) ? run_len + 1'b1 : RW'(1);
    assign apt_first   = (apt_pos == '0);
    assign apt_match   = apt_first | (bit_in == apt_ref);
    assign apt_cnt_nxt = apt_first ? CW'(1) : (apt_match ? apt_cnt + 1'b1 : apt_cnt);
    assign rct_hit     = testing & (run_nxt == RW'(RCT_CUTOFF));
    assign apt_hit     = testing & apt_match & (apt_cnt_nxt == CW'(APT_CUTOFF));
    assign fail_now    = rct_hit | apt_hit;
    assign su_nxt      = su_cnt + 1'b1;

    // A failing bit is never packed, so a failing 8th bit suppresses its push.
    assign pack        = accept & (state == RUN) & ~fail_now;
    assign byte_nxt    = {sh, bit_in};
    assign push        = pack & (bit_idx == 3'd7);
    assign pop         = out_ready & ~empty;
    assign out_valid   = ~empty;

    tt_bytefifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (byte_nxt),
        .pop   (pop),
        .flush (fail_now),
        .dout  (out_data),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_bit <= 1'b0;
            run_len  <= '0;
            apt_ref  <= 1'b0;
            apt_pos  <= '0;
            apt_cnt  <= '0;
            su_cnt   <= '0;
            sh       <= '0;
            bit_idx  <= '0;
            rct_fail <= 1'b0;
            apt_fail <= 1'b0;
            drop_cnt <= '0;
        end else begin
            case (state)
                IDLE:    if (enable) state <= STARTUP;
                STARTUP: begin
                    if (!enable)                                     state <= IDLE;
                    else if (fail_now)                               state <= FAIL;
                    else if (accept && su_nxt == SW'(STARTUP_BITS))  state <= RUN;
                end
                RUN: begin
                    if (!enable)       state <= IDLE;
                    else if (fail_now) state <= FAIL;
                end
                FAIL:    if (clear_fail) state <= enable ? STARTUP : IDLE;
                default: state <= IDLE;
            endcase

            if (state != STARTUP || clr_tests) su_cnt <= '0;
            else if (accept)                   su_cnt <= su_nxt;

            if (clr_tests) begin
                last_bit <= 1'b0;
                run_len  <= '0;
                apt_ref  <= 1'b0;
                apt_pos  <= '0;
                apt_cnt  <= '0;
                sh       <= '0;
                bit_idx  <= '0;
            end else if (testing) begin
                last_bit <= bit_in;
                run_len  <= run_nxt;
                apt_pos  <= apt_pos + 1'b1;
                apt_cnt  <= apt_cnt_nxt;
                if (apt_first) apt_ref <= bit_in;
                if (pack) begin
                    sh      <= byte_nxt[6:0];
                    bit_idx <= bit_idx + 1'b1;
                end
            end

            if (state == FAIL && clear_fail) begin
                rct_fail <= 1'b0;
                apt_fail <= 1'b0;
                drop_cnt <= '0;
            end else begin
                if (rct_hit) rct_fail <= 1'b1;
                if (apt_hit) apt_fail <= 1'b1;
                if (push && full && !pop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule
